// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller sitting in front of the shared ALU.
// Accepts one command at a time, steps the external ALU (single-cycle ops or an
// 8-iteration shift-add multiply), and holds the registered result on a
// valid/ready response port until it is consumed.
//
// state | meaning
// IDLE  | waiting for a command, ALU inputs parked at zero
// EXEC  | one cycle driving a pass-through ALU opcode
// MUL   | WIDTH shift-add iterations through the ALU adder
// RESP  | response held on rsp_* until rsp_ready
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_carry,
  output logic             rsp_greater,
  output logic             rsp_equal,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_greater,
  input  logic             alu_equal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_greater_q, rsp_greater_d;
  logic             rsp_equal_q, rsp_equal_d;
  logic             rsp_err_q, rsp_err_d;

  // one shift-add step: {carry, sum, lo} shifted right by one bit
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  // Next-state, datapath and ALU-drive decode for the current state.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    cnt_d         = cnt_q;
    rsp_lo_d      = rsp_lo_q;
    rsp_hi_d      = rsp_hi_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_greater_d = rsp_greater_q;
    rsp_equal_d   = rsp_equal_q;
    rsp_err_d     = rsp_err_q;
    cmd_ready     = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_opcode    = 3'b000;
    mul_hi_nxt    = {alu_carry, alu_result[WIDTH-1:1]};
    mul_lo_nxt    = {alu_result[0], lo_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          op_d = cmd_op[2:0];
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (!cmd_op[3]) begin
            state_d = EXEC;
          end else if (cmd_op == OP_MUL) begin
            hi_d    = '0;
            lo_d    = cmd_b;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            // reserved opcode: answer immediately with only the error flag
            rsp_lo_d      = '0;
            rsp_hi_d      = '0;
            rsp_carry_d   = 1'b0;
            rsp_greater_d = 1'b0;
            rsp_equal_d   = 1'b0;
            rsp_err_d     = 1'b1;
            state_d       = RESP;
          end
        end
      end

      EXEC: begin
        alu_a         = a_q;
        alu_b         = b_q;
        alu_opcode    = op_q;
        rsp_lo_d      = alu_result;
        rsp_hi_d      = '0;
        rsp_carry_d   = alu_carry;
        rsp_greater_d = alu_greater;
        rsp_equal_d   = alu_equal;
        rsp_err_d     = 1'b0;
        state_d       = RESP;
      end

      MUL: begin
        alu_a      = hi_q;
        alu_b      = lo_q[0] ? a_q : '0;
        alu_opcode = 3'b000;
        hi_d       = mul_hi_nxt;
        lo_d       = mul_lo_nxt;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rsp_hi_d      = mul_hi_nxt;
          rsp_lo_d      = mul_lo_nxt;
          rsp_carry_d   = (mul_hi_nxt != '0);
          rsp_equal_d   = ({mul_hi_nxt, mul_lo_nxt} == '0);
          rsp_greater_d = 1'b0;
          rsp_err_d     = 1'b0;
          state_d       = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      cnt_q         <= '0;
      rsp_lo_q      <= '0;
      rsp_hi_q      <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_greater_q <= 1'b0;
      rsp_equal_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      rsp_lo_q      <= rsp_lo_d;
      rsp_hi_q      <= rsp_hi_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_greater_q <= rsp_greater_d;
      rsp_equal_q   <= rsp_equal_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_lo      = rsp_lo_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_greater = rsp_greater_q;
  assign rsp_equal   = rsp_equal_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in for the shared ALU.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_lo;
  logic [7:0] rsp_hi;
  logic       rsp_carry;
  logic       rsp_greater;
  logic       rsp_equal;
  logic       rsp_err;
  logic       busy;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_greater;
  logic       alu_equal;

  int checks;
  int failures;
  int lat;
  logic watch;
  logic watch_bad;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_carry(rsp_carry),
    .rsp_greater(rsp_greater), .rsp_equal(rsp_equal), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_greater(alu_greater), .alu_equal(alu_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 compare, 6 shl, 7 shr
  always_comb begin
    logic [8:0] sum;
    sum         = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result  = 8'h00;
    alu_carry   = 1'b0;
    alu_greater = 1'b0;
    alu_equal   = 1'b0;
    case (alu_opcode)
      3'd0: begin alu_result = sum[7:0]; alu_carry = sum[8]; end
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: begin alu_greater = (alu_a > alu_b); alu_equal = (alu_a == alu_b); end
      3'd6: alu_result = (alu_b >= 8'd8) ? 8'h00 : (alu_a << alu_b[2:0]);
      default: alu_result = (alu_b >= 8'd8) ? 8'h00 : (alu_a >> alu_b[2:0]);
    endcase
  end

  always @(negedge clk) begin
    if (watch && alu_opcode != 3'b000) watch_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Handshake one command from IDLE, then count edges until rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int edges);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'hF; cmd_a = 8'h5A; cmd_b = 8'hA5;
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_idle"}, {29'd0, busy, rsp_valid, cmd_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; watch = 1'b0; watch_bad = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'h0);
    check("rst_valid_busy", {30'd0, rsp_valid, busy}, 32'h0);
    check("rst_rsp", {14'd0, rsp_hi, rsp_lo, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h0);
    check("rst_alu", {13'd0, alu_a, alu_b, alu_opcode}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, cmd_ready}, 32'h1);

    // add with carry out
    issue(4'd0, 8'hF0, 8'h20, lat);
    check("add_lat", lat, 1);
    check("add_res", {16'd0, rsp_hi, rsp_lo}, 32'h0010);
    check("add_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h8);
    release_rsp("add");

    // compares
    issue(4'd5, 8'h33, 8'h33, lat);
    check("cmp_eq_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h2);
    release_rsp("cmp_eq");
    issue(4'd5, 8'h40, 8'h10, lat);
    check("cmp_gt_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h4);
    release_rsp("cmp_gt");

    // multiplies
    issue(4'd8, 8'd200, 8'd150, lat);
    check("mul1_lat", lat, 8);
    check("mul1_prod", {16'd0, rsp_hi, rsp_lo}, 32'h7530);
    check("mul1_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h8);
    release_rsp("mul1");
    issue(4'd8, 8'd255, 8'd255, lat);
    check("mul2_prod", {16'd0, rsp_hi, rsp_lo}, 32'hFE01);
    check("mul2_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h8);
    release_rsp("mul2");
    issue(4'd8, 8'h12, 8'h00, lat);
    check("mul0_prod", {16'd0, rsp_hi, rsp_lo}, 32'h0000);
    check("mul0_flags", {28'd0, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h2);
    release_rsp("mul0");

    // response back-pressure: outputs hold, extra command ignored
    issue(4'd8, 8'd3, 8'd5, lat);
    check("stall_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = (i == 2); cmd_op = 4'd0; cmd_a = 8'h01; cmd_b = 8'h01;
      check("stall_hold", {14'd0, rsp_valid, cmd_ready, rsp_hi, rsp_lo}, {14'd0, 1'b1, 1'b0, 16'h000F});
    end
    cmd_valid = 1'b0;
    release_rsp("stall");
    @(posedge clk); #1;
    check("stall_no_extra", {30'd0, busy, rsp_valid}, 32'h0);
    issue(4'd0, 8'h01, 8'h02, lat);
    check("after_stall_lat", lat, 1);
    check("after_stall_res", {16'd0, rsp_hi, rsp_lo}, 32'h0003);
    release_rsp("after_stall");

    // reserved opcode
    watch = 1'b1; watch_bad = 1'b0;
    issue(4'd11, 8'h77, 8'h66, lat);
    check("rsv_lat", lat, 0);
    check("rsv_rsp", {14'd0, rsp_hi, rsp_lo, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h1);
    release_rsp("rsv");
    watch = 1'b0;
    check("rsv_opcode_zero", {31'd0, watch_bad}, 32'h0);

    // prior response is nonzero so the reset clear is visible
    issue(4'd0, 8'h01, 8'h02, lat);
    release_rsp("pre_rst");
    // reset during the 4th multiply iteration
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 8'd200; cmd_b = 8'd150;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_state", {30'd0, busy, rsp_valid}, 32'h0);
    check("midrst_rsp", {14'd0, rsp_hi, rsp_lo, rsp_carry, rsp_greater, rsp_equal, rsp_err}, 32'h0);
    watch_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) watch_bad = 1'b1;
    end
    check("midrst_no_rsp", {31'd0, watch_bad}, 32'h0);
    issue(4'd6, 8'h81, 8'd9, lat);
    check("shl_big_lat", lat, 1);
    check("shl_big_res", {16'd0, rsp_hi, rsp_lo}, 32'h0000);
    release_rsp("shl_big");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
